// File: rtl/audio_out_stream_arbiter_if.sv
// Handshake and FIFO-side bundle for audio_out_stream_arbiter.
//   master: sample sources + FIFO status (drives valid/data/mute/space, sees ready/writes/owner)
//   slave : the arbiter (sees valid/data/mute/space, drives ready/writes/owner)
interface audio_out_stream_arbiter_if #(
  parameter int unsigned AUDIO_DATA_WIDTH = 32
);
  logic                        req0_valid;
  logic [AUDIO_DATA_WIDTH-1:0] req0_left;
  logic [AUDIO_DATA_WIDTH-1:0] req0_right;
  logic                        req0_ready;
  logic                        req1_valid;
  logic [AUDIO_DATA_WIDTH-1:0] req1_left;
  logic [AUDIO_DATA_WIDTH-1:0] req1_right;
  logic                        req1_ready;
  logic                        mute;
  logic [7:0]                  left_channel_fifo_write_space;
  logic [7:0]                  right_channel_fifo_write_space;
  logic [AUDIO_DATA_WIDTH-1:0] left_channel_data;
  logic                        left_channel_data_en;
  logic [AUDIO_DATA_WIDTH-1:0] right_channel_data;
  logic                        right_channel_data_en;
  logic [1:0]                  owner;

  modport master (
    output req0_valid, req0_left, req0_right,
    output req1_valid, req1_left, req1_right,
    output mute, left_channel_fifo_write_space, right_channel_fifo_write_space,
    input  req0_ready, req1_ready,
    input  left_channel_data, left_channel_data_en,
    input  right_channel_data, right_channel_data_en,
    input  owner
  );

  modport slave (
    input  req0_valid, req0_left, req0_right,
    input  req1_valid, req1_left, req1_right,
    input  mute, left_channel_fifo_write_space, right_channel_fifo_write_space,
    output req0_ready, req1_ready,
    output left_channel_data, left_channel_data_en,
    output right_channel_data, right_channel_data_en,
    output owner
  );
endinterface

// File: rtl/audio_out_stream_arbiter.sv
// Round-robin burst arbiter sharing the stereo left/right sample FIFOs between
// two sources. One source is granted at a time for up to BURST_LEN pairs; both
// channel words are written together one cycle after acceptance, throttled on
// FIFO write space so no write ever hits a full FIFO.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of audio_out_stream_arbiter_if
//                (req0/req1 valid/left/right/ready, mute, FIFO write space,
//                 registered left/right data + enables, one-hot owner)
module audio_out_stream_arbiter #(
  parameter int unsigned AUDIO_DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN        = 16,
  parameter int unsigned SPACE_MARGIN     = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  audio_out_stream_arbiter_if.slave  bus
);

  localparam int unsigned   DW       = AUDIO_DATA_WIDTH;
  localparam int unsigned   CW       = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(BURST_LEN);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);
  localparam logic [7:0]    MARGIN   = 8'(SPACE_MARGIN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e          state_q;
  logic            rr_ptr_q;
  logic [CW-1:0]   burst_cnt_q;
  logic [DW-1:0]   left_q;
  logic [DW-1:0]   right_q;
  logic            data_en_q;
  logic [1:0]      owner_q;

  logic            space_ok;
  logic            burst_open;
  logic            hs0;
  logic            hs1;
  logic            hs;
  logic            cur_valid;
  logic [DW-1:0]   sel_left;
  logic [DW-1:0]   sel_right;

  // min(left, right) > margin is the same as both exceeding the margin.
  assign space_ok   = (bus.left_channel_fifo_write_space  > MARGIN) &&
                      (bus.right_channel_fifo_write_space > MARGIN);
  assign burst_open = (burst_cnt_q < MAX_CNT);

  assign bus.req0_ready = (state_q == GRANT0) && bus.req0_valid && space_ok && burst_open;
  assign bus.req1_ready = (state_q == GRANT1) && bus.req1_valid && space_ok && burst_open;

  assign hs0       = bus.req0_valid && bus.req0_ready;
  assign hs1       = bus.req1_valid && bus.req1_ready;
  assign hs        = hs0 || hs1;
  assign cur_valid = (state_q == GRANT0) ? bus.req0_valid : bus.req1_valid;
  assign sel_left  = hs1 ? bus.req1_left  : bus.req0_left;
  assign sel_right = hs1 ? bus.req1_right : bus.req0_right;

  // Grant FSM, burst counter and registered FIFO write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      data_en_q   <= 1'b0;
      owner_q     <= 2'b00;
    end else begin
      data_en_q <= 1'b0;
      if (hs) begin
        data_en_q <= 1'b1;
        left_q    <= bus.mute ? '0 : sel_left;
        right_q   <= bus.mute ? '0 : sel_right;
      end

      case (state_q)
        IDLE: begin
          // Never accepts here; each grant change costs this one cycle.
          if (bus.req0_valid && (!bus.req1_valid || !rr_ptr_q)) begin
            state_q <= GRANT0;
            owner_q <= 2'b01;
          end else if (bus.req1_valid) begin
            state_q <= GRANT1;
            owner_q <= 2'b10;
          end
        end
        GRANT0, GRANT1: begin
          // Release on the last pair of a burst or when the owner goes idle;
          // a valid owner stalled on space keeps the grant.
          if ((hs && (burst_cnt_q == LAST_CNT)) || !cur_valid) begin
            state_q     <= IDLE;
            owner_q     <= 2'b00;
            burst_cnt_q <= '0;
            rr_ptr_q    <= (state_q == GRANT0);
          end else if (hs) begin
            burst_cnt_q <= burst_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          owner_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus.left_channel_data     = left_q;
  assign bus.right_channel_data    = right_q;
  assign bus.left_channel_data_en  = data_en_q;
  assign bus.right_channel_data_en = data_en_q;
  assign bus.owner                 = owner_q;

endmodule

// File: tb/tb_audio_out_stream_arbiter.sv
// Directed bench for audio_out_stream_arbiter: round-robin bursts, space
// throttling, mute, early release and mid-burst reset.
module tb_audio_out_stream_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  audio_out_stream_arbiter_if #(.AUDIO_DATA_WIDTH(32)) bus ();

  audio_out_stream_arbiter #(
    .AUDIO_DATA_WIDTH(32),
    .BURST_LEN(16),
    .SPACE_MARGIN(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int tk      = 0;
  int k0      = 0;
  int k1      = 0;
  logic fixed_data = 1'b0;

  logic        en_log   [0:63];
  logic [1:0]  own_log  [0:63];
  logic [31:0] ldat_log [0:63];
  logic [31:0] rdat_log [0:63];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Source data: counters tag each pair so order/loss/duplication shows up.
  task automatic drive();
    bus.req0_left  = fixed_data ? 32'h0000_1234 : (32'h1000_0000 | 32'(k0));
    bus.req0_right = fixed_data ? 32'h0000_5678 : (32'h2000_0000 | 32'(k0));
    bus.req1_left  = 32'h3000_0000 | 32'(k1);
    bus.req1_right = 32'h4000_0000 | 32'(k1);
  endtask

  // One clock: predict the write from this cycle's handshake, check it after the edge.
  task automatic tick();
    logic        h0, h1, en_exp;
    logic [31:0] l_exp, r_exp;
    #1;
    h0     = (bus.req0_valid & bus.req0_ready) === 1'b1;
    h1     = (bus.req1_valid & bus.req1_ready) === 1'b1;
    check("ready_excl", 64'(h0 & h1), 64'(0));
    en_exp = (h0 | h1) & ~reset;
    l_exp  = bus.mute ? 32'h0 : (h1 ? bus.req1_left  : bus.req0_left);
    r_exp  = bus.mute ? 32'h0 : (h1 ? bus.req1_right : bus.req0_right);
    @(posedge clk);
    #1;
    tk++;
    if (h0) k0++;
    if (h1) k1++;
    drive();
    check("left_en", 64'(bus.left_channel_data_en), 64'(en_exp));
    check("right_en", 64'(bus.right_channel_data_en), 64'(en_exp));
    if (en_exp) begin
      check("left_data", 64'(bus.left_channel_data), 64'(l_exp));
      check("right_data", 64'(bus.right_channel_data), 64'(r_exp));
    end
    if (tk < 64) begin
      en_log[tk]   = bus.left_channel_data_en;
      own_log[tk]  = bus.owner;
      ldat_log[tk] = bus.left_channel_data;
      rdat_log[tk] = bus.right_channel_data;
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
    tk = 0;
  endtask

  function automatic int en_sum(input int a, input int b);
    int s = 0;
    for (int i = a; i <= b; i++) s += int'(en_log[i]);
    return s;
  endfunction

  function automatic int nib_cnt(input int a, input int b, input logic [3:0] nib);
    int s = 0;
    for (int i = a; i <= b; i++)
      if (en_log[i] && ldat_log[i][31:28] == nib) s++;
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.mute = 1'b0;
    bus.left_channel_fifo_write_space  = 8'd128;
    bus.right_channel_fifo_write_space = 8'd128;
    drive();

    // Reset state with both sources requesting.
    reset = 1'b1;
    repeat (2) tick();
    check("rst_owner", 64'(bus.owner), 64'(0));
    check("rst_en", 64'(bus.left_channel_data_en), 64'(0));
    check("rst_ldata", 64'(bus.left_channel_data), 64'(0));
    check("rst_rdata", 64'(bus.right_channel_data), 64'(0));
    check("rst_ready0", 64'(bus.req0_ready), 64'(0));
    check("rst_ready1", 64'(bus.req1_ready), 64'(0));
    reset = 1'b0;
    tk = 0;

    // Both valid: src0 x16, idle, src1 x16, idle, src0.
    repeat (36) tick();
    check("rr_own1", 64'(own_log[1]), 64'(2'b01));
    check("rr_src0_first", 64'(ldat_log[2]), 64'(32'h1000_0000));
    check("rr_src0_cnt", 64'(nib_cnt(2, 17, 4'h1)), 64'(16));
    check("rr_own17", 64'(own_log[17]), 64'(2'b00));
    check("rr_en18", 64'(en_log[18]), 64'(0));
    check("rr_own18", 64'(own_log[18]), 64'(2'b10));
    check("rr_src1_first", 64'(ldat_log[19]), 64'(32'h3000_0000));
    check("rr_src1_cnt", 64'(nib_cnt(19, 34, 4'h3)), 64'(16));
    check("rr_src1_last", 64'(ldat_log[34]), 64'(32'h3000_000F));
    check("rr_own34", 64'(own_log[34]), 64'(2'b00));
    check("rr_own35", 64'(own_log[35]), 64'(2'b01));
    check("rr_src0_again", 64'(ldat_log[36]), 64'(32'h1000_0010));

    // Only src0 valid: 16 on / 1 off.
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    do_reset(1);
    bus.req0_valid = 1'b1;
    repeat (34) tick();
    check("s0_burst", 64'(en_sum(1, 17)), 64'(16));
    check("s0_own17", 64'(own_log[17]), 64'(2'b00));
    check("s0_en18", 64'(en_log[18]), 64'(0));
    check("s0_own18", 64'(own_log[18]), 64'(2'b01));
    check("s0_en19", 64'(en_log[19]), 64'(1));
    check("s0_burst2", 64'(en_sum(19, 34)), 64'(16));

    // Space throttling at the margin boundary.
    bus.req0_valid = 1'b0;
    do_reset(1);
    bus.left_channel_fifo_write_space = 8'd3;
    bus.req0_valid = 1'b1;
    repeat (6) tick();
    bus.left_channel_fifo_write_space = 8'd2;
    #1;
    check("thr_ready_low", 64'(bus.req0_ready), 64'(0));
    repeat (3) tick();
    bus.left_channel_fifo_write_space = 8'd3;
    #1;
    check("thr_ready_back", 64'(bus.req0_ready), 64'(1));
    repeat (11) tick();
    check("thr_en2", 64'(en_log[2]), 64'(1));
    check("thr_pre", 64'(en_sum(1, 6)), 64'(5));
    check("thr_stall", 64'(en_sum(7, 9)), 64'(0));
    check("thr_own9", 64'(own_log[9]), 64'(2'b01));
    check("thr_total", 64'(en_sum(1, 20)), 64'(16));
    check("thr_own19", 64'(own_log[19]), 64'(2'b01));
    check("thr_own20", 64'(own_log[20]), 64'(2'b00));
    bus.left_channel_fifo_write_space = 8'd128;

    // Mute: same rate, zero data; unmute takes effect on the next accepted pair.
    bus.req0_valid = 1'b0;
    do_reset(1);
    fixed_data = 1'b1; drive();
    bus.mute = 1'b1;
    bus.req0_valid = 1'b1;
    repeat (19) tick();
    check("mute_rate", 64'(en_sum(1, 17)), 64'(16));
    check("mute_en19", 64'(en_log[19]), 64'(1));
    check("mute_ldata", 64'(ldat_log[5]), 64'(0));
    check("mute_rdata", 64'(rdat_log[5]), 64'(0));
    bus.mute = 1'b0;
    tick();
    check("unmute_ldata", 64'(ldat_log[20]), 64'(32'h0000_1234));
    check("unmute_rdata", 64'(rdat_log[20]), 64'(32'h0000_5678));
    fixed_data = 1'b0; drive();

    // src0 drops valid after 5 pairs; src1 granted next.
    bus.req0_valid = 1'b0;
    do_reset(1);
    bus.req0_valid = 1'b1;
    repeat (6) tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b1;
    repeat (3) tick();
    check("drop_cnt", 64'(en_sum(1, 6)), 64'(5));
    check("drop_own7", 64'(own_log[7]), 64'(2'b00));
    check("drop_en7", 64'(en_log[7]), 64'(0));
    check("drop_own8", 64'(own_log[8]), 64'(2'b10));
    check("drop_src1", 64'(ldat_log[9][31:28]), 64'(4'h3));

    // Reset after 7 writes of a src0 burst; src0 wins again with a full burst.
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    do_reset(1);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    repeat (8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (18) tick();
    check("mr_pre", 64'(en_sum(2, 8)), 64'(7));
    check("mr_en9", 64'(en_log[9]), 64'(0));
    check("mr_own9", 64'(own_log[9]), 64'(2'b00));
    check("mr_own10", 64'(own_log[10]), 64'(2'b01));
    check("mr_src0", 64'(ldat_log[11][31:28]), 64'(4'h1));
    check("mr_full", 64'(nib_cnt(10, 26, 4'h1)), 64'(16));
    check("mr_own26", 64'(own_log[26]), 64'(2'b00));
    check("mr_own27", 64'(own_log[27]), 64'(2'b10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_out_stream_arbiter.md
Name: audio_out_stream_arbiter

Overview:
- Shares the stereo audio-out serializer's left/right sample FIFOs between two sample sources, e.g. a tone generator and a playback engine.
- Each source offers stereo sample pairs on a valid/ready handshake.
- The block grants one source at a time in round-robin bursts and writes the left and right words in the same cycle.
- It throttles on FIFO write space, so the FIFO-full write guard never drops a sample.

Parameters:
- AUDIO_DATA_WIDTH, 32: width of each channel sample word.
- BURST_LEN, 16: maximum accepted pairs per grant before the grant is re-arbitrated.
- SPACE_MARGIN, 2: minimum write space kept in reserve, covering the status-lag cycles of the write-space outputs.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  source 0 has a stereo pair
- req0_left  in  AUDIO_DATA_WIDTH  source 0 left sample
- req0_right  in  AUDIO_DATA_WIDTH  source 0 right sample
- req0_ready  out  1  source 0 pair accepted this cycle (combinational)
- req1_valid, req1_left, req1_right, req1_ready  same as source 0
- mute  in  1  replace accepted samples with zero
- left_channel_fifo_write_space  in  8  free words in the left FIFO (0..128)
- right_channel_fifo_write_space  in  8  free words in the right FIFO
- left_channel_data  out  AUDIO_DATA_WIDTH  registered left word
- left_channel_data_en  out  1  write strobe for the left FIFO
- right_channel_data  out  AUDIO_DATA_WIDTH  registered right word
- right_channel_data_en  out  1  write strobe for the right FIFO
- owner  out  2  one-hot current grant: 01 = src0, 10 = src1, 00 = idle

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, rr_ptr 0, burst_cnt 0, all data outputs 0, both _en 0, owner 00, both ready 0.
- space_ok = (min(left_channel_fifo_write_space, right_channel_fifo_write_space) > SPACE_MARGIN).
  - Compare unsigned, at 8-bit width.
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE transitions:
  - Both valid: go to GRANT(rr_ptr).
  - Only one valid: go to that source's GRANT.
  - Neither valid: stay in IDLE.
  - IDLE never accepts a pair, so each grant change costs one cycle.
- GRANTn ready: reqn_ready = reqn_valid & space_ok & (burst_cnt < BURST_LEN). The other source's ready is 0.
- GRANTn handshake (valid & ready): burst_cnt increments.
- GRANTn release, both cases go to IDLE with rr_ptr = ~n and burst_cnt = 0:
  - a handshake with burst_cnt == BURST_LEN-1;
  - reqn_valid is 0.
- GRANTn, reqn_valid = 1 but space not ok: hold state, burst_cnt unchanged, no write.
  - A stalled grant is never released for lack of space.
- Output latency is 1 cycle. A handshake in cycle t gives in cycle t+1:
  - left_channel_data_en = right_channel_data_en = 1;
  - data = the accepted left/right words, or zero if mute was 1 in cycle t.
- Left and right _en are always identical; otherwise both are 0.
- mute does not affect the handshake or throughput.
- owner reflects the current state (registered).
- burst_cnt width is clog2(BURST_LEN+1); it never wraps.
- Reset asserted mid-burst:
  - From the next edge, outputs are at reset values.
  - A pair accepted in the same cycle as reset is not written.
- Simultaneous valid on both sources after reset: src0 wins first.

Test Plan:
- Only req0_valid held high, both spaces = 128:
  - 16 consecutive en pulses carrying data in order;
  - 1 idle cycle with owner = 00;
  - re-grant to src0, so the pattern repeats 16 on / 1 off.
- Both sources continuously valid, spaces = 128: owner sequence is src0 ×16 writes, idle, src1 ×16 writes, idle, src0…; no pair lost or duplicated.
- Write-space throttling:
  - left space = 3, right space = 128: writes proceed.
  - left space forced to 2: ready = 0 and en = 0 from the next cycle, owner is unchanged, burst_cnt frozen.
  - space restored to 3: the burst resumes and completes the remaining count.
- mute = 1 while src0 streams 0x00001234 / 0x00005678: en pulses occur at the same rate, and both data outputs are 0.
- req0_valid drops after 5 handshakes: release to IDLE. With req1 valid, src1 is granted next.
- Reset after 7 writes in a src0 burst:
  - Next cycle: en = 0, owner = 00.
  - After release with both sources valid: src0 is granted, and its burst runs a full 16.
